// File: rtl/tele_stop_pkg.sv
// tele_stop shared types.
// Holds the two interlock states.
package tele_stop_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } state_t;

endpackage

// File: rtl/tele_stop_debounce.sv
// tele_stop detector input conditioning.
// 2-flop synchronizer followed by a level debouncer.
module tele_stop_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic det
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      det <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == det) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        det <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tele_stop.sv
// tele_stop: obstacle interlock between stepper pulse
// generators and the motor drivers, with LED/buzzer status.
module tele_stop
  import tele_stop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RELEASE_CYCLES  = 50_000_000,
  parameter int BZ_HALF_PERIOD  = 12_500
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [3:0] petectIO,
  input  logic [5:0] thrusterPluseA,
  input  logic [5:0] thrusterPluseB,
  output logic [5:0] safetyPluseA,
  output logic [5:0] safetyPluseB,
  output logic       redLed,
  output logic       greenLed,
  output logic       BZ
);

  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam int BW = $clog2(BZ_HALF_PERIOD + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [BW-1:0] BZ_LAST = BW'(BZ_HALF_PERIOD - 1);

  logic [3:0]    det;
  logic          any_det;
  state_t        state;
  state_t        state_n;
  logic [RW-1:0] rel_cnt;
  logic [BW-1:0] bz_div;
  logic [11:0]   pin;
  logic [11:0]   pass;
  logic [11:0]   pulse_n;
  logic [11:0]   pulse_q;
  logic [11:0]   blk;

  for (genvar i = 0; i < 4; i++) begin : g_det
    tele_stop_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(CLK),
      .rst(RST_n),
      .din(petectIO[i]),
      .det(det[i])
    );
  end

  assign any_det = |det;

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:  if (any_det) state_n = STOP;
      STOP: if (!any_det && rel_cnt == REL_LAST) state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      state   <= RUN;
      rel_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == RUN || any_det) rel_cnt <= '0;
      else                         rel_cnt <= rel_cnt + 1'b1;
    end
  end

  // In STOP only pulses already in flight may continue; an input
  // that rose while blocked stays blocked until it drops.
  assign pin     = {thrusterPluseB, thrusterPluseA};
  assign pass    = (state == RUN) ? ~blk : pulse_q;
  assign pulse_n = pin & pass;

  // blk comes out of reset set so held inputs need a fresh edge.
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      pulse_q <= '0;
      blk     <= '1;
    end else begin
      pulse_q <= pulse_n;
      blk     <= pin & ~pulse_n;
    end
  end

  assign safetyPluseA = pulse_q[5:0];
  assign safetyPluseB = pulse_q[11:6];

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      redLed   <= 1'b0;
      greenLed <= 1'b1;
      BZ       <= 1'b0;
      bz_div   <= '0;
    end else begin
      redLed   <= (state == STOP);
      greenLed <= (state == RUN);
      if (state == RUN) begin
        BZ     <= 1'b0;
        bz_div <= '0;
      end else if (bz_div == BZ_LAST) begin
        BZ     <= ~BZ;
        bz_div <= '0;
      end else begin
        bz_div <= bz_div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tele_stop.sv
// Directed self-checking bench for tele_stop.
// Small parameters: debounce 4, release 20, buzzer half-period 3.
module tb_tele_stop;

  logic       clk;
  logic       rst;
  logic [3:0] petect;
  logic [5:0] pa;
  logic [5:0] pb;
  logic [5:0] sa;
  logic [5:0] sb;
  logic       red;
  logic       green;
  logic       bz;

  int vectors;
  int fails;

  tele_stop #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES(20),
    .BZ_HALF_PERIOD(3)
  ) dut (
    .CLK(clk),
    .RST_n(rst),
    .petectIO(petect),
    .thrusterPluseA(pa),
    .thrusterPluseB(pb),
    .safetyPluseA(sa),
    .safetyPluseB(sb),
    .redLed(red),
    .greenLed(green),
    .BZ(bz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [11:0] obs,
                     input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic r,
                        input logic g, input logic b);
    chk({tag, "_red"}, 12'(red), 12'(r));
    chk({tag, "_green"}, 12'(green), 12'(g));
    chk({tag, "_bz"}, 12'(bz), 12'(b));
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    rst     = 1'b1;
    petect  = '0;
    pa      = '0;
    pb      = '0;
    tick(2);
    chk("rst_pulses", {sb, sa}, 12'h000);
    chk_st("rst", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick(2);

    // 1: pass-through with one cycle latency
    pa[0] = 1'b1;
    pb[5] = 1'b1;
    tick(1);
    chk("t1_rise", {sb, sa}, 12'h801);
    tick(1);
    chk("t1_hold", {sb, sa}, 12'h801);
    pa[0] = 1'b0;
    pb[5] = 1'b0;
    chk("t1_lag", {sb, sa}, 12'h801);
    tick(1);
    chk("t1_fall", {sb, sa}, 12'h000);
    chk_st("t1", 1'b0, 1'b1, 1'b0);

    // 2: short glitch ignored
    petect[2] = 1'b1;
    tick(3);
    petect[2] = 1'b0;
    tick(10);
    chk_st("t2", 1'b0, 1'b1, 1'b0);

    // 3: held detector; input sampled first at edge k
    petect[1] = 1'b1;
    tick(7);
    chk("t3_red_k6", 12'(red), 12'h000);
    tick(1);
    chk_st("t3_k7", 1'b1, 1'b0, 1'b0);
    pa[1] = 1'b1;
    tick(1);
    chk("t3_blk_k8", {sb, sa}, 12'h000);
    chk("t3_bz_k8", 12'(bz), 12'h000);
    tick(1);
    chk("t3_blk_k9", {sb, sa}, 12'h000);
    chk("t3_bz_k9", 12'(bz), 12'h001);
    pa[1] = 1'b0;
    tick(3);
    chk("t3_bz_k12", 12'(bz), 12'h000);
    tick(3);
    chk("t3_bz_k15", 12'(bz), 12'h001);
    petect[1] = 1'b0;
    tick(40);
    chk_st("t3_back", 1'b0, 1'b1, 1'b0);

    // 4: pulse in flight survives STOP entry
    pa[3] = 1'b1;
    tick(1);
    chk("t4_start", {sb, sa}, 12'h008);
    petect[0] = 1'b1;
    tick(10);
    chk("t4_flight", {sb, sa}, 12'h008);
    chk("t4_red", 12'(red), 12'h001);
    pa[3] = 1'b0;
    tick(1);
    chk("t4_end", {sb, sa}, 12'h000);
    pa[3] = 1'b1;
    tick(1);
    chk("t4_blk1", {sb, sa}, 12'h000);
    tick(1);
    chk("t4_blk2", {sb, sa}, 12'h000);
    pa[3] = 1'b0;

    // 5: release restart; clear sampled first at edge p+1
    petect[0] = 1'b0;
    tick(16);
    petect[0] = 1'b1;
    tick(5);
    petect[0] = 1'b0;
    tick(9);
    chk_st("t5_p30", 1'b1, 1'b0, bz);
    chk("t5_green_p30", 12'(green), 12'h000);
    tick(17);
    chk("t5_green_p47", 12'(green), 12'h000);
    tick(1);
    chk_st("t5_p48", 1'b0, 1'b1, 1'b0);

    // 6: reset in STOP
    pb[2] = 1'b1;
    tick(1);
    chk("t6_pre", {sb, sa}, 12'h100);
    petect[3] = 1'b1;
    tick(8);
    chk("t6_stop_red", 12'(red), 12'h001);
    chk("t6_stop_pulse", {sb, sa}, 12'h100);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_pulses", {sb, sa}, 12'h000);
    chk_st("t6_rst", 1'b0, 1'b1, 1'b0);
    petect = '0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t6_no_resume", {sb, sa}, 12'h000);
    chk_st("t6_run", 1'b0, 1'b1, 1'b0);
    pb[2] = 1'b0;
    tick(1);
    pb[2] = 1'b1;
    tick(1);
    chk("t6_fresh", {sb, sa}, 12'h100);
    pb[2] = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
